prbs_tx: RTL and testbench

PRBS_TX -- requirements
Module: prbs_tx

---
 rtl/prbs_tx.sv | 154 +++++++++++++++
 tb/tb_prbs_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs_tx.sv
// PRBS bit transmitter with burst control, ready/valid handshake and period marker.
// Optional error injection is enabled by defining PRBS_TX_ERR_INJ_EN.
module prbs_tx #(
   parameter int unsigned PRBS_TYPE     = 7,
   parameter logic [31:0] SEED          = 32'h0000_0001,
   parameter int unsigned BIT_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic [BIT_CNT_WIDTH-1:0] burst_len,
   input  logic                     err_inj,
   input  logic                     dout_rdy,
   output logic                     dout_vld,
   output logic                     dout,
   output logic                     busy,
   output logic                     done,
   output logic                     seq_start,
   output logic [BIT_CNT_WIDTH-1:0] tx_cnt
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   // Feedback taps as a mask over the state; the next bit is the XOR of the selected bits.
   function automatic logic [31:0] tap_mask(int unsigned t);
      case (t)
         0:       tap_mask = 32'h0000_0005;
         1:       tap_mask = 32'h0000_0041;
         2:       tap_mask = 32'h0000_0110;
         3:       tap_mask = 32'h0000_0500;
         4:       tap_mask = 32'h0000_4001;
         5:       tap_mask = 32'h0001_0004;
         6:       tap_mask = 32'h0042_0000;
         default: tap_mask = 32'h8020_0003;
      endcase
   endfunction

   // Last value of the period counter before it wraps (sequence period minus one).
   function automatic logic [31:0] per_last(int unsigned t);
      case (t)
         0:       per_last = 32'd6;
         1:       per_last = 32'd126;
         2:       per_last = 32'd510;
         3:       per_last = 32'd2046;
         4:       per_last = 32'd32766;
         5:       per_last = 32'd131070;
         6:       per_last = 32'd8388606;
         default: per_last = 32'hFFFF_FFFE;
      endcase
   endfunction

   localparam logic [31:0] TapMask = tap_mask(PRBS_TYPE);
   localparam logic [31:0] PerLast = per_last(PRBS_TYPE);
   localparam logic [31:0] SeedEff = (SEED == 32'h0) ? 32'h1 : SEED;

   state_e                   state_q, state_d;
   logic [31:0]              sr_q, sr_d;
   logic [31:0]              per_q, per_d;
   logic [BIT_CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
   logic [BIT_CNT_WIDTH-1:0] len_q, len_d;
   logic [BIT_CNT_WIDTH-1:0] tx_cnt_inc;
   logic                     done_q, done_d;
   logic                     inj_q, inj_d;
   logic                     nb;
   logic                     xfer;
   logic                     burst_end;
   logic                     launch;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start && !stop) state_d = StRun;
         StRun:   if (stop || burst_end) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      dout_vld = (state_q == StRun);
      busy     = (state_q == StRun);
   end

   always_comb begin
      nb         = ^(sr_q & TapMask);
      xfer       = dout_vld && dout_rdy;
      launch     = (state_q == StIdle) && start && !stop;
      tx_cnt_inc = tx_cnt_q + 1'b1;
      burst_end  = xfer && (len_q != '0) && (tx_cnt_inc == len_q);

      sr_d     = xfer ? {sr_q[30:0], nb} : sr_q;
      per_d    = per_q;
      if (xfer) per_d = (per_q == PerLast) ? 32'h0 : per_q + 32'h1;

      tx_cnt_d = tx_cnt_q;
      len_d    = len_q;
      if (launch) begin
         tx_cnt_d = '0;
         len_d    = burst_len;
      end else if (xfer) begin
         tx_cnt_d = tx_cnt_inc;
      end

      done_d = burst_end;
   end

`ifdef PRBS_TX_ERR_INJ_EN
   // A pending injection is consumed by the next transfer; repeat requests while pending merge.
   always_comb begin
      inj_d = inj_q ? !xfer : err_inj;
   end
`else
   logic unused_err_inj;
   assign unused_err_inj = err_inj;
   always_comb begin
      inj_d = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q     <= SeedEff;
         per_q    <= 32'h0;
         tx_cnt_q <= '0;
         len_q    <= '0;
         done_q   <= 1'b0;
         inj_q    <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         per_q    <= per_d;
         tx_cnt_q <= tx_cnt_d;
         len_q    <= len_d;
         done_q   <= done_d;
         inj_q    <= inj_d;
      end
   end

   assign dout      = dout_vld ? (nb ^ inj_q) : 1'b0;
   assign seq_start = dout_vld && (per_q == 32'h0);
   assign done      = done_q;
   assign tx_cnt    = tx_cnt_q;

endmodule

// File: tb/tb_prbs_tx.sv
// Randomized and directed bench for prbs_tx: a type-0 and a type-1 instance share stimulus
// and are compared each cycle against a bit-history reference model.
module tb_prbs_tx;

`ifdef PRBS_TX_ERR_INJ_EN
   localparam bit InjEn = 1'b1;
`else
   localparam bit InjEn = 1'b0;
`endif
   localparam logic [31:0] Seed = 32'h0000_0001;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, stop = 1'b0, err_inj = 1'b0, dout_rdy = 1'b0;
   logic [15:0] burst_len = '0;
   logic        vld0, dout0, busy0, done0, seq0;
   logic        vld1, dout1, busy1, done1, seq1;
   logic [15:0] cnt0, cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: bit history per type, shared burst control.
   bit          q0[$], q1[$];
   int unsigned per0, per1;
   bit          m_run, m_done, m_inj;
   logic [15:0] m_cnt, m_len;

   always #5 clk = ~clk;

   prbs_tx #(.PRBS_TYPE(0), .SEED(Seed), .BIT_CNT_WIDTH(16)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .burst_len(burst_len),
      .err_inj(err_inj), .dout_rdy(dout_rdy), .dout_vld(vld0), .dout(dout0),
      .busy(busy0), .done(done0), .seq_start(seq0), .tx_cnt(cnt0)
   );

   prbs_tx #(.PRBS_TYPE(1), .SEED(Seed), .BIT_CNT_WIDTH(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .burst_len(burst_len),
      .err_inj(err_inj), .dout_rdy(dout_rdy), .dout_vld(vld1), .dout(dout1),
      .busy(busy1), .done(done1), .seq_start(seq1), .tx_cnt(cnt1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit nb_of(input bit q[$], input int a, input int b);
      return q[q.size() - 1 - a] ^ q[q.size() - 1 - b];
   endfunction

   function automatic void model_reset();
      q0.delete();
      q1.delete();
      for (int i = 31; i >= 0; i--) begin
         q0.push_back(Seed[i]);
         q1.push_back(Seed[i]);
      end
      per0 = 0; per1 = 0;
      m_run = 0; m_done = 0; m_inj = 0;
      m_cnt = '0; m_len = '0;
   endfunction

   // Asserts reset mid-cycle and checks that all outputs drop at once.
   task automatic do_reset();
      rst = 1'b0;
      start = 0; stop = 0; err_inj = 0; dout_rdy = 0;
      #1;
      model_reset();
      check("rst_vld", {vld1, vld0}, 32'h0);
      check("rst_dout", {dout1, dout0}, 32'h0);
      check("rst_busy", {busy1, busy0}, 32'h0);
      check("rst_done", {done1, done0}, 32'h0);
      check("rst_seq", {seq1, seq0}, 32'h0);
      check("rst_cnt", {cnt1, cnt0}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // One clock: drive inputs, compare at the falling edge, advance the model.
   task automatic cycle(input bit s, input bit p, input logic [15:0] len, input bit r,
                        input bit e, output bit o_d1, output bit o_s0);
      bit nb0, nb1, xfer, nd;
      start = s; stop = p; burst_len = len; dout_rdy = r; err_inj = e;
      @(negedge clk);
      nb0 = nb_of(q0, 2, 0);
      nb1 = nb_of(q1, 6, 0);
      check("vld0", vld0, m_run);
      check("vld1", vld1, m_run);
      check("busy0", busy0, m_run);
      check("busy1", busy1, m_run);
      check("done0", done0, m_done);
      check("done1", done1, m_done);
      check("cnt0", cnt0, m_cnt);
      check("cnt1", cnt1, m_cnt);
      check("dout0", dout0, m_run ? (nb0 ^ m_inj) : 1'b0);
      check("dout1", dout1, m_run ? (nb1 ^ m_inj) : 1'b0);
      check("seq0", seq0, m_run && per0 == 0);
      check("seq1", seq1, m_run && per1 == 0);
      o_d1 = dout1;
      o_s0 = seq0;

      xfer = m_run && r;
      nd   = 0;
      if (xfer) begin
         q0.push_back(nb0); void'(q0.pop_front());
         q1.push_back(nb1); void'(q1.pop_front());
         per0 = (per0 + 1) % 7;
         per1 = (per1 + 1) % 127;
         m_cnt = m_cnt + 16'd1;
      end
      if (InjEn) m_inj = m_inj ? !xfer : e;
      if (!m_run) begin
         if (s && !p) begin
            m_run = 1; m_cnt = '0; m_len = len;
         end
      end else begin
         if (xfer && m_len != 0 && m_cnt == m_len) begin
            nd = 1; m_run = 0;
         end
         if (p) m_run = 0;
      end
      m_done = nd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          d, sq;
      logic [6:0]  bits;
      logic [20:0] seqv;
      int          got;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Length-7 burst on type 1 from seed 1
      cycle(1, 0, 16'd7, 1, 0, d, sq);
      for (int i = 0; i < 7; i++) begin
         cycle(0, 0, 16'd0, 1, 0, d, sq);
         bits = {bits[5:0], d};
      end
      check("burst_bits", bits, 7'b1111110);
      cycle(0, 0, 16'd0, 1, 0, d, sq);

      // Same burst with ready toggling
      do_reset();
      cycle(1, 0, 16'd7, 1, 0, d, sq);
      got = 0;
      for (int i = 0; i < 14; i++) begin
         cycle(0, 0, 16'd0, (i % 2) == 0, 0, d, sq);
         if ((i % 2) == 0) begin
            bits = {bits[5:0], d};
            got++;
         end
      end
      check("stall_bits", bits, 7'b1111110);
      check("stall_xfers", got, 7);
      cycle(0, 0, 16'd0, 1, 0, d, sq);

      // Continuous type 0: period markers, stop on the 21st transfer
      do_reset();
      cycle(1, 0, 16'd0, 1, 0, d, sq);
      for (int i = 0; i < 21; i++) begin
         cycle(0, i == 20, 16'd0, 1, 0, d, sq);
         seqv[i] = sq;
      end
      check("seq_marks", seqv, 21'h00_4081);
      cycle(0, 0, 16'd0, 1, 0, d, sq);

      // start+stop together in idle; start while running
      cycle(1, 1, 16'd5, 1, 0, d, sq);
      cycle(0, 0, 16'd0, 1, 0, d, sq);
      cycle(1, 0, 16'd3, 1, 0, d, sq);
      cycle(0, 0, 16'd0, 1, 0, d, sq);
      cycle(1, 0, 16'd9, 1, 0, d, sq);
      for (int i = 0; i < 4; i++) cycle(0, 0, 16'd0, 1, 0, d, sq);

      // Reset after 4 of 7 transfers, then restart from the seed
      do_reset();
      cycle(1, 0, 16'd7, 1, 0, d, sq);
      for (int i = 0; i < 4; i++) cycle(0, 0, 16'd0, 1, 0, d, sq);
      do_reset();
      cycle(1, 0, 16'd7, 1, 0, d, sq);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 16'd0, 1, 0, d, sq);
         bits = {bits[5:0], d};
      end
      check("restart_bits", bits[2:0], 3'b111);

      // Error injection before the 3rd transfer
      do_reset();
      cycle(1, 0, 16'd0, 1, 0, d, sq);
      cycle(0, 0, 16'd0, 1, 0, d, sq);
      cycle(0, 0, 16'd0, 1, 1, d, sq);
      cycle(0, 0, 16'd0, 1, 0, d, sq);
      check("inj_bit", d, InjEn ? 1'b0 : 1'b1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 16'd0, 1, 0, d, sq);
      cycle(0, 1, 16'd0, 1, 0, d, sq);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         cycle($urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0,
               ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, d, sq);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
